imem_loader: RTL

Boot-time program loader upstream of the Y86-64 instruction memory. It accepts a byte stream over a valid/ready handshake, parses a 2-byte length header, and writes the payload bytes into instruction memory starting at address 0. It releases the core by asserting `cpu_run` only after the last write has landed. Malformed or oversized images latch an error and keep the core held.

---
 rtl/imem_loader_if.sv | 21 ++
 rtl/imem_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus for imem_loader.
interface imem_loader_if #(
  parameter int AW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_byte;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_wdata;

  modport master (
    output in_valid, in_byte,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: 2-byte LE length header, then payload written to imem from address 0.
// Optional trailing XOR checksum byte enabled by `IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  output logic          cpu_run,
  output logic          load_err,
  output logic [15:0]   byte_cnt
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
`ifdef IMEM_LOADER_CSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_e;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e AFTER_PAYLOAD = CSUM;
`else
  localparam state_e AFTER_PAYLOAD = DONE;
`endif

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_e        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          run_q, run_d;
  logic          err_q, err_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic          in_ready_w;
  logic          accept;
  logic [15:0]   hdr_len;

  assign accept  = bus.in_valid && in_ready_w;
  assign hdr_len = {bus.in_byte, len_q[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR0;
      len_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      HDR0: begin
        if (accept) begin
          len_d[7:0] = bus.in_byte;
          state_d    = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          len_d[15:8] = bus.in_byte;
          if ({1'b0, hdr_len} > DEPTH_W) begin
            state_d = ERR;
          end else if (hdr_len == '0) begin
            state_d = AFTER_PAYLOAD;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[AW-1:0];
          wdata_d = bus.in_byte;
          cnt_d   = cnt_q + 16'd1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = csum_q ^ bus.in_byte;
`endif
          if (cnt_q + 16'd1 == len_q) begin
            state_d = AFTER_PAYLOAD;
          end
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (accept) begin
          state_d = (bus.in_byte == csum_q) ? DONE : ERR;
        end
      end
`endif
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // cpu_run lags DONE by one edge so it never overlaps the final write strobe.
  always_comb begin
    run_d      = run_q | (state_q == DONE);
    err_d      = err_q | (state_d == ERR);
    in_ready_w = (state_q != DONE);
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_run        = run_q;
  assign load_err       = err_q;
  assign byte_cnt       = cnt_q;

endmodule
